// File: rtl/miriscv_mem_arbiter.sv
// Shares one OBI-style memory port between instruction fetch and the LSU.
// Data wins by default, a starvation counter guarantees fetch progress, and an in-order ID FIFO routes responses.
module miriscv_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           instr_req_i,
  input  logic [XLEN-1:0]                instr_addr_i,
  output logic                           instr_gnt_o,
  output logic                           instr_rvalid_o,
  output logic [XLEN-1:0]                instr_rdata_o,
  input  logic                           data_req_i,
  input  logic                           data_we_i,
  input  logic [XLEN/8-1:0]              data_be_i,
  input  logic [XLEN-1:0]                data_addr_i,
  input  logic [XLEN-1:0]                data_wdata_i,
  output logic                           data_gnt_o,
  output logic                           data_rvalid_o,
  output logic [XLEN-1:0]                data_rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [XLEN/8-1:0]              mem_be_o,
  output logic [XLEN-1:0]                mem_addr_o,
  output logic [XLEN-1:0]                mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [XLEN-1:0]                mem_rdata_i,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt_o,
  output logic                           err_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTST);
  localparam logic [PW-1:0] PTR_MAX    = PW'(MAX_OUTST - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // ID encoding in the FIFO and lock register: 1 = data, 0 = instr
  logic [MAX_OUTST-1:0] fifo_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 lock_q, lock_data_q;
  logic [SW-1:0]        starve_q;
  logic                 err_q;

  logic sel_data, sel_req, full, empty, push, pop, head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    if (lock_q)
      sel_data = lock_data_q;
    else if (starve_q == STARVE_MAX && instr_req_i)
      sel_data = 1'b0;
    else
      sel_data = data_req_i;
    sel_req   = sel_data ? data_req_i : instr_req_i;
    full      = (cnt_q == CNT_MAX);
    empty     = (cnt_q == '0);
    head_data = fifo_q[rd_ptr_q];
    push      = mem_req_o & mem_gnt_i;
    pop       = mem_rvalid_i & ~empty;
  end

  assign mem_req_o   = sel_req & ~full;
  assign mem_we_o    = sel_data & data_we_i;
  assign mem_be_o    = sel_data ? data_be_i : '1;
  assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = sel_data ? data_wdata_i : '0;

  assign instr_gnt_o = push & ~sel_data;
  assign data_gnt_o  = push & sel_data;

  assign instr_rvalid_o = pop & ~head_data;
  assign data_rvalid_o  = pop & head_data;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign outst_cnt_o = cnt_q;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      lock_data_q <= 1'b0;
      starve_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel_data;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)
        cnt_q <= cnt_q + CW'(1);
      else if (!push && pop)
        cnt_q <= cnt_q - CW'(1);
      if (mem_rvalid_i && empty)
        err_q <= 1'b1;
      // A stalled request keeps its owner until granted; while full the lock is frozen
      if (!full) begin
        lock_q      <= mem_req_o & ~mem_gnt_i;
        lock_data_q <= sel_data;
      end
      if (instr_req_i && !instr_gnt_o) begin
        if (starve_q != STARVE_MAX)
          starve_q <= starve_q + SW'(1);
      end else begin
        starve_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter: stimulus pushes expected response owners/data,
// a monitor pops and compares whenever an rvalid output fires.
module tb_miriscv_mem_arbiter;
  localparam int XLEN = 32;
  localparam bit ID_I = 1'b0;
  localparam bit ID_D = 1'b1;

  logic            clk_i = 1'b0;
  logic            arstn_i;
  logic            instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [XLEN-1:0] instr_addr_i, instr_rdata_o;
  logic            data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [3:0]      data_be_i, mem_be_o;
  logic [XLEN-1:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic            mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]      outst_cnt_o;
  logic            err_o;

  int checks = 0;
  int errors = 0;
  bit          exp_id_q[$];
  logic [31:0] exp_data_q[$];

  miriscv_mem_arbiter #(.XLEN(XLEN), .MAX_OUTST(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .outst_cnt_o(outst_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change right after the falling edge; state updates on the rising edge
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic drv(input logic ir, input logic dr, input logic g, input logic rv, input logic [31:0] rd);
    instr_req_i  = ir;
    data_req_i   = dr;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
  endtask

  // Response monitor
  initial begin
    bit          id;
    logic [31:0] d;
    forever begin
      @(negedge clk_i);
      #2;
      if (instr_rvalid_o || data_rvalid_o) begin
        chk("rvalid_onehot", {30'd0, instr_rvalid_o, data_rvalid_o} == 32'd3, 32'd0);
        if (exp_id_q.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
        end else begin
          id = exp_id_q.pop_front();
          d  = exp_data_q.pop_front();
          chk("resp_owner_is_data", {31'd0, data_rvalid_o}, {31'd0, id});
          chk("resp_rdata", data_rvalid_o ? data_rdata_o : instr_rdata_o, d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    arstn_i = 1'b0;
    drv(0, 0, 0, 0, 32'h0);
    instr_addr_i = 32'h0; data_we_i = 1'b0; data_be_i = 4'hF;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    repeat (2) tick();
    #1;
    chk("rst_outst", {30'd0, outst_cnt_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    tick(); arstn_i = 1'b1;

    // Single fetch
    tick(); instr_addr_i = 32'h80; drv(1, 0, 1, 0, 0); #1;
    chk("t1_mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("t1_mem_be", {28'd0, mem_be_o}, 32'hF);
    chk("t1_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("t1_mem_addr", mem_addr_o, 32'h80);
    chk("t1_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'b10);
    exp_id_q.push_back(ID_I);
    tick(); drv(0, 0, 0, 0, 0); #1;
    chk("t1_outst", {30'd0, outst_cnt_o}, 32'd1);
    tick(); drv(0, 0, 0, 1, 32'h13); exp_data_q.push_back(32'h13); #1;
    chk("t1_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'b10);
    tick(); drv(0, 0, 0, 0, 0); #1;
    chk("t1_outst_end", {30'd0, outst_cnt_o}, 32'd0);

    // Both requesting, memory always grants: D,D,D,D,I repeating
    begin
      bit pat[10] = '{ID_D, ID_D, ID_D, ID_D, ID_I, ID_D, ID_D, ID_D, ID_D, ID_I};
      instr_addr_i = 32'h100; data_addr_i = 32'h200;
      for (int k = 0; k < 10; k++) begin
        tick();
        drv(1, 1, 1, k > 0, 32'h100 + k);
        if (k > 0) exp_data_q.push_back(32'h100 + k);
        #1;
        chk($sformatf("t2_gnt_%0d", k), {30'd0, instr_gnt_o, data_gnt_o},
            pat[k] ? 32'b01 : 32'b10);
        exp_id_q.push_back(pat[k]);
      end
      tick(); drv(0, 0, 0, 1, 32'h10A); exp_data_q.push_back(32'h10A);
      tick(); drv(0, 0, 0, 0, 0); #1;
      chk("t2_outst_end", {30'd0, outst_cnt_o}, 32'd0);
    end

    // Stalled data write holds the port even after fetch reaches the starve threshold
    data_we_i = 1'b1; data_be_i = 4'b0011; data_addr_i = 32'h300; data_wdata_i = 32'hDEAD;
    instr_addr_i = 32'h84;
    for (int k = 0; k < 6; k++) begin
      tick(); drv(k > 0, 1, 0, 0, 0); #1;
      chk($sformatf("t3_addr_%0d", k), mem_addr_o, 32'h300);
      chk($sformatf("t3_we_be_%0d", k), {27'd0, mem_we_o, mem_be_o}, {27'd0, 1'b1, 4'b0011});
      chk($sformatf("t3_nogrant_%0d", k), {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
    end
    tick(); drv(1, 1, 1, 0, 0); #1;
    chk("t3_data_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'b01);
    chk("t3_wdata", mem_wdata_o, 32'hDEAD);
    exp_id_q.push_back(ID_D);
    tick(); drv(1, 1, 1, 0, 0); #1;
    chk("t3_instr_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'b10);
    chk("t3_instr_addr", mem_addr_o, 32'h84);
    chk("t3_instr_we_be", {27'd0, mem_we_o, mem_be_o}, 32'h0F);
    chk("t3_instr_wdata", mem_wdata_o, 32'h0);
    exp_id_q.push_back(ID_I);
    tick(); drv(0, 0, 0, 1, 32'h55); exp_data_q.push_back(32'h55); #1;
    chk("t3_write_resp", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'b01);
    tick(); drv(0, 0, 0, 1, 32'h66); exp_data_q.push_back(32'h66);
    tick(); drv(0, 0, 0, 0, 0);
    data_we_i = 1'b0; data_be_i = 4'hF;

    // Outstanding limit
    instr_addr_i = 32'h90;
    tick(); drv(1, 0, 1, 0, 0); exp_id_q.push_back(ID_I);
    tick(); drv(1, 0, 1, 0, 0); exp_id_q.push_back(ID_I);
    tick(); drv(1, 0, 1, 0, 0); #1;
    chk("t4_full_req", {31'd0, mem_req_o}, 32'd0);
    chk("t4_full_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
    chk("t4_full_outst", {30'd0, outst_cnt_o}, 32'd2);
    tick(); drv(1, 0, 1, 1, 32'h1); exp_data_q.push_back(32'h1); #1;
    chk("t4_rv_req", {31'd0, mem_req_o}, 32'd0);
    chk("t4_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'b10);
    tick(); drv(1, 0, 1, 0, 0); #1;
    chk("t4_outst_1", {30'd0, outst_cnt_o}, 32'd1);
    chk("t4_reissue", {30'd0, mem_req_o, instr_gnt_o}, 32'b11);
    exp_id_q.push_back(ID_I);
    tick(); drv(0, 0, 0, 1, 32'h2); exp_data_q.push_back(32'h2);
    tick(); drv(0, 0, 0, 1, 32'h3); exp_data_q.push_back(32'h3);
    tick(); drv(0, 0, 0, 0, 0); #1;
    chk("t4_outst_end", {30'd0, outst_cnt_o}, 32'd0);

    // Interleaved I, D, I with in-order responses
    instr_addr_i = 32'hA0; data_addr_i = 32'h400;
    tick(); drv(1, 0, 1, 0, 0); exp_id_q.push_back(ID_I);
    tick(); drv(0, 1, 1, 0, 0); #1;
    chk("t5_data_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'b01);
    exp_id_q.push_back(ID_D);
    tick(); drv(0, 0, 0, 1, 32'hA); exp_data_q.push_back(32'hA);
    tick(); drv(1, 0, 1, 1, 32'hB); exp_data_q.push_back(32'hB); exp_id_q.push_back(ID_I); #1;
    chk("t5_rv_b", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'b01);
    tick(); drv(0, 0, 0, 1, 32'hC); exp_data_q.push_back(32'hC);
    tick(); drv(0, 0, 0, 0, 0); #1;
    chk("t5_outst_end", {30'd0, outst_cnt_o}, 32'd0);

    // Protocol error and reset mid-transaction
    tick(); drv(0, 0, 0, 1, 32'hBAD); #1;
    chk("t6_stray_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    tick(); drv(0, 0, 0, 0, 0); #1;
    chk("t6_err_set", {31'd0, err_o}, 32'd1);
    tick(); drv(1, 0, 1, 0, 0);
    tick(); drv(0, 0, 0, 0, 0); #1;
    chk("t6_err_sticky", {31'd0, err_o}, 32'd1);
    chk("t6_outst_1", {30'd0, outst_cnt_o}, 32'd1);
    arstn_i = 1'b0; #1;
    chk("t6_rst_outst", {30'd0, outst_cnt_o}, 32'd0);
    chk("t6_rst_err", {31'd0, err_o}, 32'd0);
    tick(); arstn_i = 1'b1;
    tick(); drv(0, 0, 0, 1, 32'h77); #1;
    chk("t6_late_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    tick(); drv(0, 0, 0, 0, 0); #1;
    chk("t6_late_err", {31'd0, err_o}, 32'd1);

    repeat (2) tick();
    chk("sb_ids_drained", exp_id_q.size(), 32'd0);
    chk("sb_data_drained", exp_data_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
